// File: rtl/quan_sa_feeder.sv
// Systolic-array feeder: configures the array for a job, streams jointly consumed
// weight/pixel beats, pulses output-enable, waits out the array drain and signals done.
module quan_sa_feeder #(
  parameter int ROW_NUM   = 16,
  parameter int COL_NUM   = 16,
  parameter int DRAIN_CYC = ROW_NUM + COL_NUM + 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             mode_cfg,
  input  logic [7:0]             k_len,
  input  logic                   w_valid,
  input  logic [8*ROW_NUM-1:0]   w_data,
  output logic                   w_ready,
  input  logic                   p_valid,
  input  logic [16*COL_NUM-1:0]  p_data,
  output logic                   p_ready,
  output logic                   sa_reset,
  output logic [3:0]             sa_mode_init,
  output logic                   sa_en,
  output logic                   sa_output_en,
  output logic [8*ROW_NUM-1:0]   sa_row_in,
  output logic [16*COL_NUM-1:0]  sa_column_in,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {IDLE, CFG, STREAM, OUT, DRAIN, DONE} state_t;

  // Drain counter runs 0..DRAIN_CYC-1.
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  state_t          state;
  logic [7:0]      k_q;
  logic [7:0]      beat_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            fire;

  // Both streams advance together so weights and pixels never slip out of step.
  assign fire    = (state == STREAM) & w_valid & p_valid;
  assign w_ready = fire;
  assign p_ready = fire;
  assign busy    = (state != IDLE);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; the default pulse clears at the top are then safely overridden.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      k_q          <= '0;
      beat_cnt     <= '0;
      drain_cnt    <= '0;
      sa_reset     <= 1'b0;
      sa_mode_init <= '0;
      sa_en        <= 1'b0;
      sa_output_en <= 1'b0;
      sa_row_in    <= '0;
      sa_column_in <= '0;
      done         <= 1'b0;
    end else begin
      sa_reset     <= 1'b0;
      sa_output_en <= 1'b0;
      done         <= 1'b0;
      // A cycle without a joint beat feeds the array a zero bubble.
      sa_en        <= fire;
      sa_row_in    <= fire ? w_data : '0;
      sa_column_in <= fire ? p_data : '0;

      case (state)
        IDLE: begin
          if (start && (k_len != 8'd0)) begin
            sa_mode_init <= mode_cfg;
            k_q          <= k_len;
            sa_reset     <= 1'b1;
            state        <= CFG;
          end
        end
        CFG: begin
          beat_cnt <= '0;
          state    <= STREAM;
        end
        STREAM: begin
          if (fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt + 8'd1 == k_q) state <= OUT;
          end
        end
        OUT: begin
          sa_output_en <= 1'b1;
          drain_cnt    <= '0;
          state        <= DRAIN;
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= DONE;
          else                         drain_cnt <= drain_cnt + 1'b1;
        end
        DONE: begin
          // done lands in IDLE, so a start alongside it is accepted.
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quan_sa_feeder.sv
// Directed self-checking bench for quan_sa_feeder: basic job, stalls, one-sided
// valid, ignored starts, mid-job reset and back-to-back jobs.
module tb_quan_sa_feeder;

  localparam int ROW_NUM   = 16;
  localparam int COL_NUM   = 16;
  localparam int DRAIN_CYC = ROW_NUM + COL_NUM + 4;
  localparam int WW        = 8 * ROW_NUM;
  localparam int PW        = 16 * COL_NUM;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    mode_cfg;
  logic [7:0]    k_len;
  logic          w_valid;
  logic [WW-1:0] w_data;
  logic          w_ready;
  logic          p_valid;
  logic [PW-1:0] p_data;
  logic          p_ready;
  logic          sa_reset;
  logic [3:0]    sa_mode_init;
  logic          sa_en;
  logic          sa_output_en;
  logic [WW-1:0] sa_row_in;
  logic [PW-1:0] sa_column_in;
  logic          busy;
  logic          done;

  quan_sa_feeder #(.ROW_NUM(ROW_NUM), .COL_NUM(COL_NUM), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_cfg(mode_cfg), .k_len(k_len),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready),
    .sa_reset(sa_reset), .sa_mode_init(sa_mode_init), .sa_en(sa_en),
    .sa_output_en(sa_output_en), .sa_row_in(sa_row_in), .sa_column_in(sa_column_in),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int beat_idx = 0;
  int base     = 0;

  int rst_cnt, rst_cyc, en_cnt, en_first, en_last, oe_cnt, oe_cyc, done_cnt, done_cyc;
  int bubble_err, ready_err, stall_ready;
  logic [3:0]    mode_seen;
  logic [WW-1:0] en_rows[$];
  logic [PW-1:0] en_cols[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk_w(input int i);
    logic [WW-1:0] v;
    for (int r = 0; r < ROW_NUM; r++) v[r*8 +: 8] = 8'(i * 16 + r + 1);
    return v;
  endfunction

  function automatic logic [PW-1:0] mk_p(input int i);
    logic [PW-1:0] v;
    for (int c = 0; c < COL_NUM; c++) v[c*16 +: 16] = 16'(i * 256 + c * 3 + 16'h5000);
    return v;
  endfunction

  task automatic clear_log();
    rst_cnt = 0; rst_cyc = 0; en_cnt = 0; en_first = 0; en_last = 0;
    oe_cnt = 0; oe_cyc = 0; done_cnt = 0; done_cyc = 0;
    bubble_err = 0; ready_err = 0; stall_ready = 0; mode_seen = 4'hx;
    en_rows.delete(); en_cols.delete();
  endtask

  // One clock: sample readies before the edge, outputs 1 time unit after it.
  task automatic step();
    logic fired;
    #1;
    fired = w_ready;
    if (w_ready !== p_ready) ready_err++;
    if (!p_valid && (w_ready || p_ready)) stall_ready++;
    @(posedge clk);
    #1;
    cyc++;
    if (fired) beat_idx++;
    w_data = mk_w(beat_idx);
    p_data = mk_p(beat_idx);
    if (sa_reset) begin rst_cnt++; rst_cyc = cyc; mode_seen = sa_mode_init; end
    if (sa_en) begin
      if (en_cnt == 0) en_first = cyc;
      en_last = cyc;
      en_cnt++;
      en_rows.push_back(sa_row_in);
      en_cols.push_back(sa_column_in);
    end
    if (sa_output_en) begin oe_cnt++; oe_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (!sa_en && (sa_row_in != '0 || sa_column_in != '0)) bubble_err++;
  endtask

  // Starts a job and runs to its done pulse. p_valid drops for stall_len cycles once
  // stall_at beats are consumed; pulse_at >= 0 pulses a stray start mid-job.
  task automatic run_job(input logic [3:0] mode, input logic [7:0] k,
                         input int stall_at, input int stall_len, input int pulse_at);
    int stall_done = 0;
    clear_log();
    base = beat_idx;
    w_valid = 1'b1; p_valid = 1'b1;
    mode_cfg = mode; k_len = k; start = 1'b1;
    for (int j = -1; j < 400 && done_cnt == 0; j++) begin
      if (j >= 0) begin
        start = (j == pulse_at);
        if (start) k_len = 8'd3;
      end
      step();
      start = 1'b0;
      if (stall_len > 0 && beat_idx - base == stall_at && stall_done < stall_len) begin
        p_valid = 1'b0;
        stall_done++;
      end else begin
        p_valid = 1'b1;
      end
    end
    check("job_finished", int'(done_cnt > 0), 1);
    repeat (3) step();
  endtask

  task automatic check_beats(input string tag);
    for (int i = 0; i < en_rows.size(); i++) begin
      check({tag, "_row"}, en_rows[i], mk_w(base + i));
      check({tag, "_col"}, en_cols[i], mk_p(base + i));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sa_reset"}, sa_reset, 0);
    check({tag, "_sa_en"}, sa_en, 0);
    check({tag, "_output_en"}, sa_output_en, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_w_ready"}, w_ready, 0);
    check({tag, "_p_ready"}, p_ready, 0);
    check({tag, "_mode_init"}, sa_mode_init, 0);
    check({tag, "_row_in"}, sa_row_in, 0);
    check({tag, "_col_in"}, sa_column_in, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_log();
    reset = 1'b1; start = 1'b0; mode_cfg = 4'd0; k_len = 8'd0;
    w_valid = 1'b1; p_valid = 1'b1;
    w_data = mk_w(0); p_data = mk_p(0);
    #3;
    check_all_zero("por");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic job: done on the 43rd cycle counting the CFG cycle as the first.
    run_job(4'd0, 8'd3, -1, 0, -1);
    check("basic_rst_cnt", rst_cnt, 1);
    check("basic_mode", mode_seen, 0);
    check("basic_en_cnt", en_cnt, 3);
    check("basic_en_first", en_first - rst_cyc, 2);
    check("basic_en_span", en_last - en_first, 2);
    check_beats("basic");
    check("basic_oe_cnt", oe_cnt, 1);
    check("basic_oe_after_en", oe_cyc - en_last, 1);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_latency", done_cyc - rst_cyc, 3 + DRAIN_CYC + 3);
    check("basic_bubble", bubble_err, 0);
    check("basic_ready_pair", ready_err, 0);
    check("basic_idle_busy", busy, 0);

    // Two-cycle pixel stall after beat 2; mode 9 passes through untouched.
    run_job(4'd9, 8'd4, 2, 2, -1);
    check("stall_mode", mode_seen, 9);
    check("stall_en_cnt", en_cnt, 4);
    check("stall_en_span", en_last - en_first, 5);
    check_beats("stall");
    check("stall_ready_low", stall_ready, 0);
    check("stall_bubble", bubble_err, 0);
    check("stall_latency", done_cyc - rst_cyc, 4 + DRAIN_CYC + 3 + 2);
    check("stall_oe_after_en", oe_cyc - en_last, 1);

    // Weights valid alone for 5 STREAM cycles (pixel valid also low in CFG).
    run_job(4'd0, 8'd2, 0, 6, -1);
    check("onesided_ready_low", stall_ready, 0);
    check("onesided_en_cnt", en_cnt, 2);
    check_beats("onesided");
    check("onesided_latency", done_cyc - rst_cyc, 2 + DRAIN_CYC + 3 + 5);

    // k_len = 0 start is ignored.
    clear_log();
    mode_cfg = 4'd3; k_len = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("kzero_busy", busy, 0);
    check("kzero_no_cfg", rst_cnt, 0);

    // Stray start during DRAIN is ignored.
    run_job(4'd2, 8'd2, -1, 0, 10);
    check("busystart_rst_cnt", rst_cnt, 1);
    check("busystart_done_cnt", done_cnt, 1);
    check("busystart_idle", busy, 0);

    // Reset after beat 2 of a 5-beat job.
    clear_log();
    base = beat_idx;
    w_valid = 1'b1; p_valid = 1'b1; mode_cfg = 4'd9; k_len = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 20 && beat_idx - base < 2; j++) step();
    check("midrst_beats_before", beat_idx - base, 2);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (3) step();
    reset = 1'b0;
    repeat (60) step();
    check("midrst_no_done", done_cnt, 0);

    // Recovery job after reset.
    run_job(4'd1, 8'd1, -1, 0, -1);
    check("recover_mode", mode_seen, 1);
    check("recover_en_cnt", en_cnt, 1);
    check_beats("recover");
    check("recover_latency", done_cyc - rst_cyc, 1 + DRAIN_CYC + 3);
    check("recover_mode_hold", sa_mode_init, 1);

    // start held high: second CFG cycle directly follows done.
    clear_log();
    base = beat_idx;
    w_valid = 1'b1; p_valid = 1'b1; mode_cfg = 4'd0; k_len = 8'd2; start = 1'b1;
    for (int j = 0; j < 400 && done_cnt == 0; j++) step();
    check("b2b_first_done", done_cnt, 1);
    step();
    check("b2b_rst_cnt", rst_cnt, 2);
    check("b2b_cfg_after_done", rst_cyc - done_cyc, 1);
    start = 1'b0;
    for (int j = 0; j < 400 && done_cnt < 2; j++) step();
    check("b2b_second_done", done_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
